// File: rtl/matrix_link_driver.sv
// Matrix link driver: stores two 3x3 operand matrices, presses them one by one
// into an external multiplier over a btn/switches link, then samples the nine
// result values from the multiplier's leds on a fixed display schedule.
module matrix_link_driver #(
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned SAMPLE_OFFSET  = 50_000_000,
  parameter int unsigned DISPLAY_PERIOD = 100_000_001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_we,
  input  logic [4:0] load_addr,
  input  logic [7:0] load_data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       btn,
  output logic [7:0] switches,
  input  logic [7:0] leds,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  // Handshake: start is a one-cycle request sampled only while idle; busy is
  // high from the cycle after an accepted start until the done cycle, and done
  // pulses for exactly one cycle with busy already low.

  typedef enum logic [2:0] {
    S_IDLE, S_PRESS, S_RELEASE, S_WAIT_FIRST, S_SAMPLE, S_DONE
  } state_e;

  localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GAP_LAST    = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] OFFSET_LAST = 32'(SAMPLE_OFFSET - 1);
  localparam logic [31:0] PERIOD_LAST = 32'(DISPLAY_PERIOD - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  k_q, k_d;
  logic [7:0]  sw_q, sw_d;
  logic [7:0]  opnd_q [18];
  logic [7:0]  res_q  [9];

  logic       opnd_we;
  logic       cap_we;
  logic [3:0] cap_addr;
  logic       first_hit;
  logic       sample_hit;
  logic [7:0] first_operand;

  assign first_hit  = (state_q == S_WAIT_FIRST) && (cnt_q == OFFSET_LAST);
  assign sample_hit = (state_q == S_SAMPLE) && (cnt_q == PERIOD_LAST);
  assign opnd_we    = load_we && (load_addr <= 5'd17) && !busy;
  // A write to A[0] in the same cycle as start must reach the first press.
  assign first_operand = (opnd_we && (load_addr == 5'd0)) ? load_data : opnd_q[0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (start) state_d = S_PRESS;
      S_PRESS:      if (cnt_q == HOLD_LAST) state_d = S_RELEASE;
      S_RELEASE:    if (cnt_q == GAP_LAST) state_d = (idx_q == 5'd17) ? S_WAIT_FIRST : S_PRESS;
      S_WAIT_FIRST: if (first_hit) state_d = S_SAMPLE;
      S_SAMPLE:     if (sample_hit && (k_q == 4'd8)) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Output decode: btn is high only in PRESS, so it drops at once on reset
  always_comb begin
    btn      = (state_q == S_PRESS);
    busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    done     = (state_q == S_DONE);
    switches = sw_q;
  end

  // Datapath next values: phase counter, element index, capture index, switches
  always_comb begin
    cnt_d    = cnt_q + 32'd1;
    idx_d    = idx_q;
    k_d      = k_q;
    sw_d     = sw_q;
    cap_we   = 1'b0;
    cap_addr = k_q;
    if ((state_d != state_q) || sample_hit) cnt_d = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          idx_d = '0;
          sw_d  = first_operand;
        end
      end
      S_RELEASE: begin
        if (state_d == S_PRESS) begin
          idx_d = idx_q + 5'd1;
          sw_d  = opnd_q[idx_q + 5'd1];
        end
      end
      S_WAIT_FIRST: begin
        if (first_hit) begin
          cap_we   = 1'b1;
          cap_addr = 4'd0;
          k_d      = 4'd1;
        end
      end
      S_SAMPLE: begin
        if (sample_hit) begin
          cap_we   = 1'b1;
          cap_addr = k_q;
          k_d      = k_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      k_q   <= '0;
      sw_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      k_q   <= k_d;
      sw_q  <= sw_d;
    end
  end

  // Operand and result storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 18; i++) opnd_q[i] <= '0;
      for (int i = 0; i < 9; i++)  res_q[i]  <= '0;
    end else begin
      if (opnd_we) opnd_q[load_addr] <= load_data;
      if (cap_we)  res_q[cap_addr]   <= leds;
    end
  end

  // Result read port; out-of-range indices read as zero
  always_comb begin
    rd_data = (rd_addr <= 4'd8) ? res_q[rd_addr] : 8'd0;
  end

endmodule

// File: tb/tb_matrix_link_driver.sv
// Directed bench for matrix_link_driver with short timing parameters.
module tb_matrix_link_driver;

  localparam int HOLD   = 2;
  localparam int GAP    = 2;
  localparam int OFFSET = 5;
  localparam int PERIOD = 10;
  // Edge index (after the start edge E0) of the first sample and of done.
  localparam int FIRST_SAMPLE = 18 * (HOLD + GAP) + OFFSET;
  localparam int DONE_N       = FIRST_SAMPLE + 8 * PERIOD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_we = 1'b0;
  logic [4:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic       start = 1'b0;
  logic       busy, done, btn;
  logic [7:0] switches;
  logic [7:0] leds = '0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the last run_xfer call
  int         pulses, hold_err, gap_err, sw_err, done_cnt, done_n;
  logic       busy_first, busy_at_done, done_after, busy_after, timeout;
  logic [7:0] first_sw;
  logic [7:0] sw_log [$];

  matrix_link_driver #(
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
    .SAMPLE_OFFSET(OFFSET), .DISPLAY_PERIOD(PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .start(start), .busy(busy), .done(done),
    .btn(btn), .switches(switches), .leds(leds), .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_seq(input int i);
    if (i < 9) return 8'(i + 1);
    return (((i - 9) % 4) == 0) ? 8'd1 : 8'd0;
  endfunction

  task automatic load(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // Drives one transfer and records link behaviour; leds_mode 1 = 10,20..90,
  // 2 = product of the captured operands. Stops early on abort_press.
  task automatic run_xfer(input int leds_mode, input int inject_press,
                          input int abort_press, input bit same_load);
    logic       prev_btn;
    logic [7:0] prev_sw;
    int run, j, m, acc;
    pulses = 0; hold_err = 0; gap_err = 0; sw_err = 0; done_cnt = 0; done_n = -1;
    timeout = 1'b1; first_sw = '0; busy_first = 1'b0; busy_at_done = 1'b1;
    done_after = 1'b1; busy_after = 1'b1; sw_log.delete();
    prev_btn = 1'b0; run = 0;
    @(negedge clk);
    prev_sw = switches;
    start = 1'b1;
    if (same_load) begin load_we = 1'b1; load_addr = 5'd0; load_data = 8'h42; end
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      start = 1'b0; load_we = 1'b0;
      if (n == 0) busy_first = busy;
      if (btn !== prev_btn) begin
        if (prev_btn && run != HOLD) hold_err++;
        if (!prev_btn && pulses > 0 && run != GAP) gap_err++;
        run = 1;
      end else run++;
      if (btn && prev_btn && switches !== prev_sw) sw_err++;
      if (btn && !prev_btn) begin
        sw_log.push_back(switches);
        pulses++;
        if (pulses == 1) first_sw = switches;
        if (pulses == abort_press) begin rst = 1'b1; timeout = 1'b0; return; end
        if (pulses == inject_press) begin
          start = 1'b1; load_we = 1'b1; load_addr = 5'd0; load_data = 8'h55;
        end
      end
      if (done_cnt > 0 && n == done_n + 1) begin
        done_after = done; busy_after = busy; timeout = 1'b0;
        break;
      end
      if (done === 1'b1) begin done_cnt++; done_n = n; busy_at_done = busy; end
      m = n + 1;
      leds = '0;
      if (m >= FIRST_SAMPLE) begin
        j = (m - FIRST_SAMPLE) / PERIOD;
        if (j > 8) j = 8;
        if (leds_mode == 1) leds = 8'(10 * (j + 1));
        else if (sw_log.size() == 18) begin
          acc = 0;
          for (int t = 0; t < 3; t++) acc += sw_log[(j / 3) * 3 + t] * sw_log[9 + t * 3 + (j % 3)];
          leds = 8'(acc);
        end
      end
      prev_btn = btn; prev_sw = switches;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (btn !== 1'b0) begin n_fail++; $display("FAIL reset_btn: got %b want 0", btn); end
    n_checks++; if (switches !== 8'd0) begin n_fail++; $display("FAIL reset_switches: got %0d want 0", switches); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      n_checks++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL reset_rd[%0d]: got %0d want 0", a, rd_data); end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic check_full_run(input string tag);
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: no done within budget", tag); end
    n_checks++; if (pulses != 18) begin n_fail++; $display("FAIL %s_pulses: got %0d want 18", tag, pulses); end
    for (int i = 0; i < 18 && i < sw_log.size(); i++) begin
      n_checks++;
      if (sw_log[i] !== exp_seq(i)) begin n_fail++; $display("FAIL %s_sw[%0d]: got %0d want %0d", tag, i, sw_log[i], exp_seq(i)); end
    end
    n_checks++; if (hold_err != 0) begin n_fail++; $display("FAIL %s_hold: %0d bad high widths want 0", tag, hold_err); end
    n_checks++; if (gap_err != 0) begin n_fail++; $display("FAIL %s_gap: %0d bad low widths want 0", tag, gap_err); end
    n_checks++; if (sw_err != 0) begin n_fail++; $display("FAIL %s_sw_stable: %0d changes while btn high want 0", tag, sw_err); end
    n_checks++; if (busy_first !== 1'b1) begin n_fail++; $display("FAIL %s_busy_start: got %b want 1", tag, busy_first); end
    n_checks++; if (done_n != DONE_N) begin n_fail++; $display("FAIL %s_done_time: got %0d want %0d", tag, done_n, DONE_N); end
    n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL %s_busy_at_done: got %b want 0", tag, busy_at_done); end
    n_checks++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL %s_done_width: got %b want 0", tag, done_after); end
    n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL %s_busy_after: got %b want 0", tag, busy_after); end
    for (int a = 0; a < 9; a++) begin
      rd_addr = 4'(a); #1;
      n_checks++;
      if (rd_data !== 8'(10 * (a + 1))) begin n_fail++; $display("FAIL %s_c[%0d]: got %0d want %0d", tag, a, rd_data, 10 * (a + 1)); end
    end
  endtask

  task automatic test_transfer();
    for (int i = 0; i < 18; i++) load(5'(i), exp_seq(i));
    run_xfer(1, 0, 0, 1'b0);
    check_full_run("xfer");
  endtask

  task automatic test_busy_ignore();
    run_xfer(1, 3, 0, 1'b0);
    check_full_run("busy");
  endtask

  task automatic test_reset_abort();
    run_xfer(1, 0, 5, 1'b0);
    #1;
    n_checks++; if (first_sw !== 8'd1) begin n_fail++; $display("FAIL abort_a0_kept: got %0d want 1", first_sw); end
    n_checks++; if (pulses != 5) begin n_fail++; $display("FAIL abort_pulses: got %0d want 5", pulses); end
    n_checks++; if (btn !== 1'b0) begin n_fail++; $display("FAIL abort_btn: got %b want 0", btn); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (switches !== 8'd0) begin n_fail++; $display("FAIL abort_switches: got %0d want 0", switches); end
    for (int a = 0; a < 9; a++) begin
      rd_addr = 4'(a); #1;
      n_checks++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL abort_rd[%0d]: got %0d want 0", a, rd_data); end
    end
    @(negedge clk); rst = 1'b0;
    run_xfer(1, 0, 1, 1'b0);
    n_checks++; if (first_sw !== 8'd0) begin n_fail++; $display("FAIL abort_cleared_a0: got %0d want 0", first_sw); end
    n_checks++; if (busy_first !== 1'b1) begin n_fail++; $display("FAIL abort_restart_busy: got %b want 1", busy_first); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_load_with_start();
    run_xfer(1, 0, 1, 1'b1);
    n_checks++; if (first_sw !== 8'h42) begin n_fail++; $display("FAIL same_cycle_load: got %0h want 42", first_sw); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_identity();
    for (int i = 0; i < 18; i++) load(5'(i), ((i % 9) % 4 == 0) ? 8'd1 : 8'd0);
    run_xfer(2, 0, 0, 1'b0);
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL ident_timeout: no done within budget"); end
    n_checks++; if (pulses != 18) begin n_fail++; $display("FAIL ident_pulses: got %0d want 18", pulses); end
    for (int a = 0; a < 9; a++) begin
      rd_addr = 4'(a); #1;
      n_checks++;
      if (rd_data !== ((a % 4 == 0) ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL ident_c[%0d]: got %0d want %0d", a, rd_data, (a % 4 == 0) ? 1 : 0); end
    end
  endtask

  task automatic test_bad_addr();
    load(5'd20, 8'h77);
    rd_addr = 4'd12; #1;
    n_checks++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL bad_rd12: got %0d want 0", rd_data); end
    for (int a = 0; a < 9; a++) begin
      rd_addr = 4'(a); #1;
      n_checks++;
      if (rd_data !== ((a % 4 == 0) ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL bad_keep_c[%0d]: got %0d want %0d", a, rd_data, (a % 4 == 0) ? 1 : 0); end
    end
    // Confirm no operand changed: A and B still identity on the link
    run_xfer(2, 0, 0, 1'b0);
    for (int i = 0; i < 18 && i < sw_log.size(); i++) begin
      n_checks++;
      if (sw_log[i] !== (((i % 9) % 4 == 0) ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL bad_keep_op[%0d]: got %0d", i, sw_log[i]); end
    end
    n_checks++; if (pulses != 18) begin n_fail++; $display("FAIL bad_pulses: got %0d want 18", pulses); end
  endtask

  initial begin
    test_reset();
    test_transfer();
    test_busy_ignore();
    test_reset_abort();
    test_load_with_start();
    test_identity();
    test_bad_addr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
